// File: rtl/usb_rw_sequencer.sv
// Two-phase USB read/write sequencer in front of ProtocolFSM: address OUT, then data OUT/IN.
// Optional per-phase watchdog and wdog_fired output are enabled with RW_WATCHDOG_EN.
`timescale 1ns/1ps
module usb_rw_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'd5,
    parameter logic [3:0]  ADDR_ENDP   = 4'd4,
    parameter logic [3:0]  DATA_ENDP   = 4'd8,
    parameter int unsigned RETRY_MAX   = 2
`ifdef RW_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 4096
`endif
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        start,
    input  logic        rw,
    input  logic [15:0] mem_addr,
    input  logic [63:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        success,
    output logic [63:0] rd_data,
    output logic        send_in,
    output logic        input_ready,
    output logic [63:0] data,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    input  logic        free,
    input  logic        cancel,
    input  logic        recv_ready,
    input  logic [63:0] data_recv
`ifdef RW_WATCHDOG_EN
    ,
    output logic        wdog_fired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_A_ISSUE = 3'd1,
        S_A_WAIT  = 3'd2,
        S_D_ISSUE = 3'd3,
        S_D_WAIT  = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [2:0] RETRY_LIM = 3'(RETRY_MAX);

    state_t      state_q, state_d;
    logic [2:0]  retry_q, retry_d;
    logic        rw_q, rw_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [63:0] rd_data_q, rd_data_d;
    logic        success_q, success_d;
    logic        issue;
    logic        in_wait;
    logic        wait_event;
    logic        timeout_fire;

    assign in_wait    = (state_q == S_A_WAIT) || (state_q == S_D_WAIT);
    assign wait_event = cancel
                      || ((state_q == S_A_WAIT) && free)
                      || ((state_q == S_D_WAIT) && (rw_q ? recv_ready : free));

`ifdef RW_WATCHDOG_EN
    localparam int unsigned WDOG_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_fired_q;

    // Fire on the cycle whose increment would land on the limit, so done
    // appears exactly WDOG_CYCLES cycles after the issue pulse.
    assign timeout_fire = in_wait && !wait_event && ((wdog_cnt_q + 1'b1) == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            wdog_cnt_q   <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            if (input_ready) begin
                wdog_cnt_q <= '0;
            end else if (in_wait) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
            wdog_fired_q <= timeout_fire;
        end
    end

    assign wdog_fired = wdog_fired_q;
`else
    assign timeout_fire = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        state_d    = state_q;
        retry_d    = retry_q;
        rw_d       = rw_q;
        mem_addr_d = mem_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        success_d  = success_q;
        issue      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d       = rw;
                    mem_addr_d = mem_addr;
                    wr_data_d  = wr_data;
                    retry_d    = '0;
                    state_d    = S_A_ISSUE;
                end
            end
            S_A_ISSUE: begin
                if (free) begin
                    issue   = 1'b1;
                    state_d = S_A_WAIT;
                end
            end
            S_A_WAIT: begin
                if (cancel) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_A_ISSUE;
                    end else begin
                        success_d = 1'b0;
                        state_d   = S_FIN;
                    end
                end else if (free) begin
                    retry_d = '0;
                    state_d = S_D_ISSUE;
                end else if (timeout_fire) begin
                    success_d = 1'b0;
                    state_d   = S_FIN;
                end
            end
            S_D_ISSUE: begin
                if (free) begin
                    issue   = 1'b1;
                    state_d = S_D_WAIT;
                end
            end
            S_D_WAIT: begin
                // Returned IN data wins over a cancel seen in the same cycle.
                if (rw_q && recv_ready) begin
                    rd_data_d = data_recv;
                    success_d = 1'b1;
                    state_d   = S_FIN;
                end else if (cancel) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 3'd1;
                        state_d = S_D_ISSUE;
                    end else begin
                        success_d = 1'b0;
                        state_d   = S_FIN;
                    end
                end else if (!rw_q && free) begin
                    success_d = 1'b1;
                    state_d   = S_FIN;
                end else if (timeout_fire) begin
                    success_d = 1'b0;
                    state_d   = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            retry_q    <= '0;
            rw_q       <= 1'b0;
            mem_addr_q <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            success_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q    <= state_d;
            retry_q    <= retry_d;
            rw_q       <= rw_d;
            mem_addr_q <= mem_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            success_q  <= success_d;
        end
    end

    // Transaction fields decode from state and latched request only, so they
    // hold steady from issue through the wait while ProtocolFSM resends.
    always_comb begin
        send_in = 1'b0;
        endp    = '0;
        data    = '0;
        case (state_q)
            S_A_ISSUE, S_A_WAIT: begin
                endp = ADDR_ENDP;
                data = {48'b0, mem_addr_q};
            end
            S_D_ISSUE, S_D_WAIT: begin
                endp    = DATA_ENDP;
                send_in = rw_q;
                data    = rw_q ? 64'b0 : wr_data_q;
            end
            default: begin
                send_in = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign success     = success_q;
    assign rd_data     = rd_data_q;
    assign input_ready = issue;
    assign addr        = DEV_ADDR;

    a_ir_single: assert property (@(posedge clk) disable iff (!rst_L)
        input_ready |=> !input_ready);
    a_done_single: assert property (@(posedge clk) disable iff (!rst_L)
        done |=> !done);
    a_wait_stable: assert property (@(posedge clk) disable iff (!rst_L)
        in_wait |-> $stable({send_in, endp, data}));

endmodule
